// File: rtl/vending_pkg.sv
// ---------------------------------------------------------------------------
// vending_pkg
// Definitions shared between the coin accumulator and the vend stage:
//  - state_t       : transaction state (IDLE / COLLECT / LOCKED / REFUND)
//  - CREDIT_W      : width of the credit bus handed to the vend stage
//  - DEFAULT_DENOM*: default coin values indexed by coin_type
//  - DEFAULT_MAX_CREDIT / DEFAULT_TIMEOUT_CYCLES : default limits
// No ports (package).
// ---------------------------------------------------------------------------
package vending_pkg;

   localparam int CREDIT_W               = 8;
   localparam int DEFAULT_DENOM0         = 5;
   localparam int DEFAULT_DENOM1         = 10;
   localparam int DEFAULT_DENOM2         = 20;
   localparam int DEFAULT_DENOM3         = 50;
   localparam int DEFAULT_MAX_CREDIT     = 200;
   localparam int DEFAULT_TIMEOUT_CYCLES = 1000;
   localparam int COIN_COUNT_W           = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_COLLECT = 2'b01,
      ST_LOCKED  = 2'b10,
      ST_REFUND  = 2'b11
   } state_t;

endpackage

// File: rtl/inactivity_timer.sv
// ---------------------------------------------------------------------------
// inactivity_timer
// Counts enabled cycles since the last restart. expire is high during the
// enabled cycle in which the count has reached TIMEOUT_CYCLES-1, so the
// owner can change state on the following edge. The count holds while
// enable is low, which is how the accumulator freezes it during a lock.
// Ports:
//  clk     in  1  rising-edge clock
//  reset   in  1  synchronous, active-high
//  enable  in  1  count this cycle
//  restart in  1  return the count to zero (wins over enable)
//  expire  out 1  enabled cycle at terminal count
// ---------------------------------------------------------------------------
module inactivity_timer #(
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic restart,
   output logic expire
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count;
   logic             at_terminal;

   assign at_terminal = (count == TERMINAL);
   assign expire      = enable && at_terminal;

   // The count stops at the terminal value; the owner leaves the counting
   // state on expiry and only a restart brings the count back to zero.
   always_ff @(posedge clk) begin
      if (reset || restart) begin
         count <= '0;
      end else if (enable && !at_terminal) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/coin_accumulator.sv
// ---------------------------------------------------------------------------
// coin_accumulator
// Turns coin-acceptor pulses into the running credit used by the vend stage.
// Coins that would push the credit above MAX_CREDIT, or that arrive while
// the vend stage is busy, clearing, or a refund is pending, are returned.
// After TIMEOUT_CYCLES idle cycles with credit present a refund is requested.
// Ports:
//  clk          in  1  rising-edge clock
//  reset        in  1  synchronous, active-high
//  coin_valid   in  1  coin presented this cycle
//  coin_type    in  2  denomination index
//  lock         in  1  vend stage busy (level)
//  clear        in  1  transaction finished, zero the credit
//  insert_cash  out 8  accumulated credit
//  credit_valid out 1  state is COLLECT
//  coin_reject  out 1  presented coin returned (one-cycle pulse)
//  coin_count   out 4  coins accepted this transaction, saturating
//  refund_req   out 1  state is REFUND
// ---------------------------------------------------------------------------
module coin_accumulator
   import vending_pkg::*;
#(
   parameter int DENOM0         = DEFAULT_DENOM0,
   parameter int DENOM1         = DEFAULT_DENOM1,
   parameter int DENOM2         = DEFAULT_DENOM2,
   parameter int DENOM3         = DEFAULT_DENOM3,
   parameter int MAX_CREDIT     = DEFAULT_MAX_CREDIT,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    coin_valid,
   input  logic [1:0]              coin_type,
   input  logic                    lock,
   input  logic                    clear,
   output logic [CREDIT_W-1:0]     insert_cash,
   output logic                    credit_valid,
   output logic                    coin_reject,
   output logic [COIN_COUNT_W-1:0] coin_count,
   output logic                    refund_req
);

   localparam logic [CREDIT_W:0]       MAX_SUM   = (CREDIT_W+1)'(MAX_CREDIT);
   localparam logic [COIN_COUNT_W-1:0] COUNT_SAT = '1;

   state_t              state;
   logic [CREDIT_W-1:0] denom;
   logic [CREDIT_W:0]   sum;
   logic                accepting;
   logic                coin_accept;
   logic                timer_enable;
   logic                timer_restart;
   logic                timer_expire;

   // Denomination lookup and the 9-bit sum so an overflow past 255 can
   // never wrap into an apparently legal credit.
   always_comb begin
      denom = '0;
      case (coin_type)
         2'b00:   denom = CREDIT_W'(DENOM0);
         2'b01:   denom = CREDIT_W'(DENOM1);
         2'b10:   denom = CREDIT_W'(DENOM2);
         default: denom = CREDIT_W'(DENOM3);
      endcase
      sum = {1'b0, insert_cash} + {1'b0, denom};
   end

   // A coin is taken only when nothing of higher priority is happening and
   // the result stays within the ceiling; every other presented coin is
   // rejected. The timer runs only on quiet COLLECT cycles.
   always_comb begin
      accepting     = (state == ST_IDLE) || (state == ST_COLLECT);
      coin_accept   = coin_valid && accepting && !lock && !clear && (sum <= MAX_SUM);
      timer_enable  = (state == ST_COLLECT) && !lock && !clear && !coin_accept;
      timer_restart = clear || coin_accept;
   end

   inactivity_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .enable (timer_enable),
      .restart(timer_restart),
      .expire (timer_expire)
   );

   // Transaction FSM with registered outputs. credit_valid and refund_req
   // are written alongside the state so they always match it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         insert_cash  <= '0;
         coin_count   <= '0;
         credit_valid <= 1'b0;
         coin_reject  <= 1'b0;
         refund_req   <= 1'b0;
      end else begin
         coin_reject <= coin_valid && !coin_accept;
         if (clear) begin
            state        <= ST_IDLE;
            insert_cash  <= '0;
            coin_count   <= '0;
            credit_valid <= 1'b0;
            refund_req   <= 1'b0;
         end else begin
            case (state)
               ST_IDLE, ST_COLLECT: begin
                  if (lock) begin
                     state        <= ST_LOCKED;
                     credit_valid <= 1'b0;
                  end else if (coin_accept) begin
                     state        <= ST_COLLECT;
                     insert_cash  <= sum[CREDIT_W-1:0];
                     credit_valid <= 1'b1;
                     if (coin_count != COUNT_SAT) begin
                        coin_count <= coin_count + COIN_COUNT_W'(1);
                     end
                  end else if (timer_expire) begin
                     state        <= ST_REFUND;
                     credit_valid <= 1'b0;
                     refund_req   <= 1'b1;
                  end
               end
               ST_LOCKED: begin
                  if (!lock) begin
                     if (insert_cash != '0) begin
                        state        <= ST_COLLECT;
                        credit_valid <= 1'b1;
                     end else begin
                        state <= ST_IDLE;
                     end
                  end
               end
               default: begin
                  state <= ST_REFUND;
               end
            endcase
         end
      end
   end

endmodule
